// File: rtl/mux_n_rr.sv
// mux_n_rr: N-channel registered mux with manual or round-robin select.
// Optional MUX_N_RR_STATS_EN adds a saturating 16-bit transfer counter.
module mux_n_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_N_RR_STATS_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    localparam int NPAD = 2 ** SEL_W;

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [NPAD-1:0]  valid_pad;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W:0]   sum;

    logic             rr_vld;
    logic [SEL_W-1:0] rr_idx;
    logic             man_vld;
    logic             grant_vld;
    logic [SEL_W-1:0] grant;
    logic             load;
    logic             xfer;

    logic             nxt_valid;
    logic [WIDTH-1:0] nxt_data;
    logic [SEL_W-1:0] nxt_chan;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Pad valids so any select value indexes a defined bit.
    assign valid_pad = NPAD'(in_valid);

    // Round-robin search: first valid channel after ptr, wrapping.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        sum    = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(CHANNELS))
                sum = sum - (SEL_W+1)'(CHANNELS);
            if (!rr_vld && valid_pad[sum[SEL_W-1:0]]) begin
                rr_vld = 1'b1;
                rr_idx = sum[SEL_W-1:0];
            end
        end
    end

    // Manual grant only for an in-range, valid channel.
    always_comb begin
        man_vld = ({1'b0, sel} < (SEL_W+1)'(CHANNELS))
                  && valid_pad[sel];
    end

    // Pick the grant source for the current mode.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        unique case (1'b1)
            mode: begin
                grant_vld = rr_vld;
                grant     = rr_idx;
            end
            !mode: begin
                grant_vld = man_vld;
                grant     = sel;
            end
            default: ;
        endcase
    end

    assign load = !out_valid || out_ready;
    assign xfer = grant_vld && load && !reset;

    // One-hot accept toward the granted channel only.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (xfer && grant == SEL_W'(i))
                in_ready[i] = 1'b1;
        end
    end

    // Next output-register contents; hold unless load.
    always_comb begin
        nxt_valid = out_valid;
        nxt_data  = out_data;
        nxt_chan  = out_chan;
        if (load) begin
            nxt_valid = grant_vld;
            if (grant_vld) begin
                nxt_data = chan_data[grant];
                nxt_chan = grant;
            end
        end
    end

    // Output register; reset discards any held word.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else begin
            out_valid <= nxt_valid;
            out_data  <= nxt_data;
            out_chan  <= nxt_chan;
        end
    end

    // Round-robin pointer follows the last round-robin transfer.
    always_ff @(posedge clock) begin
        if (reset)
            ptr <= SEL_W'(CHANNELS - 1);
        else if (xfer && mode)
            ptr <= grant;
    end

`ifdef MUX_N_RR_STATS_EN
    // Saturating count of accepted input words.
    always_ff @(posedge clock) begin
        if (reset)
            xfer_count <= '0;
        else if (xfer && xfer_count != 16'hFFFF)
            xfer_count <= xfer_count + 16'd1;
    end
`endif

endmodule
